// File: rtl/wb_regfile_if.sv
// Write-back and read-port bundle for wb_regfile: master drives writes and read indices, slave returns data/status.
interface wb_regfile_if;
  logic        wb_valid;
  logic        wb_ready;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        stall;
  logic [4:0]  ra_addr;
  logic [4:0]  rb_addr;
  logic [31:0] ra_data;
  logic [31:0] rb_data;
  logic        pend;
  logic [15:0] commit_cnt;

  modport master (
    output wb_valid, wb_addr, wb_data, stall, ra_addr, rb_addr,
    input  wb_ready, ra_data, rb_data, pend, commit_cnt
  );

  modport slave (
    input  wb_valid, wb_addr, wb_data, stall, ra_addr, rb_addr,
    output wb_ready, ra_data, rb_data, pend, commit_cnt
  );
endinterface

// File: rtl/wb_regfile.sv
// 32x32 register file with a one-entry pending write stage: commit one edge after capture, combinational bypassed reads.
// Backpressure: wb_ready drops only while a write is pending and stall holds it.
module wb_regfile (
  input  logic         clk,
  input  logic         rst_n,
  wb_regfile_if.slave  bus
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] PEND = 1'b1;

  logic [0:0]  state;
  logic [4:0]  p_addr;
  logic [31:0] p_data;
  logic [15:0] commit_cnt;
  logic [31:0] regs [32];

  logic xfer;
  logic commit;
  logic ready;

  assign ready  = (state == IDLE) || !bus.stall;
  assign xfer   = bus.wb_valid && ready;
  assign commit = (state == PEND) && !bus.stall;

  assign bus.wb_ready   = ready;
  assign bus.pend       = (state == PEND);
  assign bus.commit_cnt = commit_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else if (xfer) begin
      state <= PEND;
    end else if (commit) begin
      state <= IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_addr <= '0;
      p_data <= '0;
    end else if (xfer) begin
      p_addr <= bus.wb_addr;
      p_data <= bus.wb_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      commit_cnt <= '0;
    end else if (commit) begin
      commit_cnt <= commit_cnt + 16'd1;
    end
  end

  // Writes to r0 still count as commits but never touch storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) begin
        regs[i] <= '0;
      end
    end else if (commit && (p_addr != 5'd0)) begin
      regs[p_addr] <= p_data;
    end
  end

  always_comb begin
    bus.ra_data = regs[bus.ra_addr];
    if (bus.ra_addr == 5'd0) begin
      bus.ra_data = '0;
    end else if ((state == PEND) && (bus.ra_addr == p_addr)) begin
      bus.ra_data = p_data;
    end
  end

  always_comb begin
    bus.rb_data = regs[bus.rb_addr];
    if (bus.rb_addr == 5'd0) begin
      bus.rb_data = '0;
    end else if ((state == PEND) && (bus.rb_addr == p_addr)) begin
      bus.rb_data = p_data;
    end
  end

endmodule

// File: tb/tb_wb_regfile.sv
// Bench for wb_regfile: queue-based reference model checked every negedge, plus directed literal scenarios.
module tb_wb_regfile;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  bit   chk_en = 1'b0;

  wb_regfile_if bus();

  wb_regfile dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
  } ent_t;

  ent_t        pq[$];
  logic [31:0] m_mem [32];
  logic [15:0] m_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_read(input logic [4:0] a);
    if (a != 5'd0 && pq.size() != 0 && pq[0].a == a) return pq[0].d;
    return m_mem[a];
  endfunction

  // Reference: at most one write waits; a stalled waiting write blocks new ones.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pq.delete();
      for (int i = 0; i < 32; i++) m_mem[i] = '0;
      m_cnt = '0;
    end else begin
      logic can_take;
      ent_t e;
      can_take = !(pq.size() != 0 && bus.stall);
      if (pq.size() != 0 && !bus.stall) begin
        e = pq.pop_front();
        if (e.a != 5'd0) m_mem[e.a] = e.d;
        m_cnt = m_cnt + 16'd1;
      end
      if (bus.wb_valid && can_take) begin
        e.a = bus.wb_addr;
        e.d = bus.wb_data;
        pq.push_back(e);
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_ready", {31'd0, bus.wb_ready}, {31'd0, !(pq.size() != 0 && bus.stall)});
      chk("m_pend",  {31'd0, bus.pend}, {31'd0, pq.size() != 0});
      chk("m_cnt",   {16'd0, bus.commit_cnt}, {16'd0, m_cnt});
      chk("m_ra",    bus.ra_data, m_read(bus.ra_addr));
      chk("m_rb",    bus.rb_data, m_read(bus.rb_addr));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [4:0] a, input logic [31:0] d);
    bus.wb_valid = v;
    bus.wb_addr  = a;
    bus.wb_data  = d;
  endtask

  initial begin
    drive(1'b0, 5'd0, 32'd0);
    bus.stall   = 1'b0;
    bus.ra_addr = 5'd0;
    bus.rb_addr = 5'd0;
    chk_en = 1'b1;
    #2;
    // Reset state
    bus.ra_addr = 5'd5;
    #1;
    chk("rst_pend",  {31'd0, bus.pend}, 32'd0);
    chk("rst_ready", {31'd0, bus.wb_ready}, 32'd1);
    chk("rst_cnt",   {16'd0, bus.commit_cnt}, 32'd0);
    chk("rst_ra",    bus.ra_data, 32'd0);
    step();
    step();
    rst_n = 1'b1;

    // Single write with bypass then commit
    drive(1'b1, 5'd5, 32'hDEADBEEF);
    #1;
    chk("w5_pre_ra", bus.ra_data, 32'd0);
    step();
    drive(1'b0, 5'd0, 32'd0);
    #1;
    chk("w5_pend", {31'd0, bus.pend}, 32'd1);
    chk("w5_byp",  bus.ra_data, 32'hDEADBEEF);
    step();
    chk("w5_pend0", {31'd0, bus.pend}, 32'd0);
    chk("w5_arr",   bus.ra_data, 32'hDEADBEEF);
    chk("w5_cnt",   {16'd0, bus.commit_cnt}, 32'd1);

    // Stall holds the pending write and blocks the next one
    drive(1'b1, 5'd7, 32'h11111111);
    bus.ra_addr = 5'd7;
    step();
    drive(1'b1, 5'd7, 32'h22222222);
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("st_ready", {31'd0, bus.wb_ready}, 32'd0);
      chk("st_byp",   bus.ra_data, 32'h11111111);
      chk("st_cnt",   {16'd0, bus.commit_cnt}, 32'd1);
      step();
    end
    bus.stall = 1'b0;
    #1;
    chk("st_rel_ready", {31'd0, bus.wb_ready}, 32'd1);
    step();
    drive(1'b0, 5'd0, 32'd0);
    #1;
    chk("st_pend2", {31'd0, bus.pend}, 32'd1);
    chk("st_byp2",  bus.ra_data, 32'h22222222);
    chk("st_cnt2",  {16'd0, bus.commit_cnt}, 32'd2);
    step();
    chk("st_arr",  bus.ra_data, 32'h22222222);
    chk("st_cnt3", {16'd0, bus.commit_cnt}, 32'd3);

    // Back-to-back writes r1..r4
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 5'(i), 32'hA0000000 + 32'(i));
      #1;
      chk("b2b_ready", {31'd0, bus.wb_ready}, 32'd1);
      step();
      chk("b2b_pend", {31'd0, bus.pend}, 32'd1);
    end
    drive(1'b0, 5'd0, 32'd0);
    step();
    for (int i = 1; i <= 4; i++) begin
      bus.ra_addr = 5'(i);
      bus.rb_addr = 5'(5 - i);
      #1;
      chk("b2b_ra", bus.ra_data, 32'hA0000000 + 32'(i));
      chk("b2b_rb", bus.rb_data, 32'hA0000000 + 32'(5 - i));
    end
    chk("b2b_cnt", {16'd0, bus.commit_cnt}, 32'd7);

    // Write to r0 is counted but invisible
    bus.ra_addr = 5'd0;
    drive(1'b1, 5'd0, 32'hFFFFFFFF);
    step();
    drive(1'b0, 5'd0, 32'd0);
    #1;
    chk("r0_pend", {31'd0, bus.pend}, 32'd1);
    chk("r0_byp",  bus.ra_data, 32'd0);
    step();
    chk("r0_arr", bus.ra_data, 32'd0);
    chk("r0_cnt", {16'd0, bus.commit_cnt}, 32'd8);

    // Mid-cycle reset discards a pending write
    bus.ra_addr = 5'd9;
    bus.rb_addr = 5'd5;
    drive(1'b1, 5'd9, 32'hCAFEF00D);
    step();
    drive(1'b0, 5'd0, 32'd0);
    #1;
    chk("mr_pend1", {31'd0, bus.pend}, 32'd1);
    chk("mr_byp",   bus.ra_data, 32'hCAFEF00D);
    rst_n = 1'b0;
    #1;
    chk("mr_pend0", {31'd0, bus.pend}, 32'd0);
    chk("mr_ready", {31'd0, bus.wb_ready}, 32'd1);
    chk("mr_ra",    bus.ra_data, 32'd0);
    chk("mr_rb",    bus.rb_data, 32'd0);
    chk("mr_cnt",   {16'd0, bus.commit_cnt}, 32'd0);
    step();
    step();
    rst_n = 1'b1;
    bus.ra_addr = 5'd10;
    drive(1'b1, 5'd10, 32'h0BADF00D);
    step();
    drive(1'b0, 5'd0, 32'd0);
    bus.rb_addr = 5'd9;
    #1;
    chk("mr_first_pend", {31'd0, bus.pend}, 32'd1);
    chk("mr_first_byp",  bus.ra_data, 32'h0BADF00D);
    chk("mr_r9",         bus.rb_data, 32'd0);
    step();
    chk("mr_cnt1", {16'd0, bus.commit_cnt}, 32'd1);

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      drive(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom);
      bus.stall   = ($urandom_range(0, 9) < 3);
      bus.ra_addr = 5'($urandom_range(0, 7));
      bus.rb_addr = ($urandom_range(0, 3) == 0) ? bus.ra_addr : 5'($urandom_range(0, 31));
      step();
    end

    // Counter wrap
    drive(1'b0, 5'd0, 32'd0);
    bus.stall = 1'b0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 65535; i++) begin
      drive(1'b1, 5'($urandom_range(0, 31)), $urandom);
      step();
    end
    drive(1'b0, 5'd0, 32'd0);
    step();
    chk("wrap_ffff", {16'd0, bus.commit_cnt}, 32'h0000FFFF);
    drive(1'b1, 5'd3, 32'h12345678);
    step();
    drive(1'b0, 5'd0, 32'd0);
    step();
    chk("wrap_zero", {16'd0, bus.commit_cnt}, 32'd0);
    chk("wrap_pend", {31'd0, bus.pend}, 32'd0);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
